alu_arbiter: RTL and testbench
==============================

ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 Parameter: ALU_LATENCY, default 1, meaning cycles from alu_* inputs driven to alu_out valid (legal 0..7).
REQ-002 clk  input  1  sole clock, rising-edge.
REQ-003 rst  input  1  asynchronous, active-high reset.
REQ-004 req_valid_0 / req_valid_1  input  1 each  requester n presents an operation.
REQ-005 req_ready_0 / req_ready_1  output  1 each  requester n operation accepted this cycle.
REQ-006 req_a_n / req_b_n  input  32 each  operands of requester n.
REQ-007 req_op_n  input  3  operation select of requester n.
REQ-008 req_la_n / req_as_n  input  1 each  logic_arithmetic and add_sub of requester n.
REQ-009 rsp_valid_n  output  1  result available for requester n.
REQ-010 rsp_data_n  output  32  result for requester n.
REQ-011 rsp_ready_n  input  1  requester n consumes the result.
REQ-012 alu_operand_a / alu_operand_b  output  32  operands to the shared ALU.
REQ-013 alu_operation  output  3; alu_logic_arithmetic, alu_add_sub  output  1 each  ALU control.
REQ-014 alu_out  input  32  shared ALU result.
REQ-015 busy  output  1  high in any state other than IDLE.

Function
REQ-016 FSM states: IDLE, EXEC, RESP; one operation in flight at a time.
REQ-017 IDLE: req_ready_n = 1 combinationally only for the granted requester n, and only when req_valid_n = 1; the other ready is 0.
REQ-018 Grant: if exactly one valid, that requester; if both valid, the requester not equal to last_grant (round-robin).
REQ-019 Handshake (valid & ready in IDLE): latch a, b, op, la, as and owner id; last_grant <= owner; next state EXEC.
REQ-020 alu_* outputs are driven from the latched registers at all times; they change only on handshake.
REQ-021 EXEC lasts exactly ALU_LATENCY+1 cycles, timed by a 3-bit down-counter; on the edge ending the last EXEC cycle, alu_out is captured into a 32-bit result register; next state RESP.
REQ-022 RESP: rsp_valid_owner = 1, rsp_data_owner = result register; non-owner rsp_valid = 0.
REQ-023 RESP to IDLE on rsp_ready_owner = 1; otherwise hold RESP with data stable.
REQ-024 No request is accepted in EXEC or RESP; req_ready_0 = req_ready_1 = 0.
REQ-025 rsp_data_n for a non-owner, and for the owner outside RESP, reads 0.
REQ-026 Minimum issue-to-issue spacing: ALU_LATENCY+3 cycles (1 IDLE + ALU_LATENCY+1 EXEC + 1 RESP).
REQ-027 A requester dropping req_valid before handshake is legal; no state change occurs.
REQ-028 The round-robin pointer advances only on a handshake, never on idle cycles.

Reset
REQ-029 rst asserted, at any time including mid-EXEC or mid-RESP: state = IDLE, in-flight operation discarded, no rsp_valid.
REQ-030 Reset values: all latched operand/control registers 0, result 0, counter 0, last_grant = 1 (so requester 0 wins the first tie), busy 0.
REQ-031 All outputs are 0 during reset.

Verification
REQ-032 The bench ALU stub drives alu_out = alu_operand_a + alu_operand_b, delayed by ALU_LATENCY registers; ALU_LATENCY = 1.
REQ-033 Single request: req0 a=2, b=1 -> req_ready_0 in the same cycle; rsp_valid_0 = 1 with rsp_data_0 = 3 exactly 3 cycles after the handshake.
REQ-034 Tie after reset: both valid, req0 a=5, b=5 and req1 a=7, b=1 -> req0 granted first with rsp_data_0 = 10; req1 granted next with rsp_data_1 = 8; grants alternate on repeated ties.
REQ-035 Backpressure: rsp_ready_0 = 0 for 4 cycles in RESP -> rsp_valid_0 and rsp_data_0 held stable; req1 valid throughout gets no ready until the cycle after rsp_ready_0 = 1.
REQ-036 Reset mid-EXEC: rst pulsed on the 1st EXEC cycle -> next cycle busy = 0, no rsp_valid; a fresh req1 a=1, b=1 yields rsp_data_1 = 2.
REQ-037 Latency sweep: ALU_LATENCY = 0 and 3 -> response appears ALU_LATENCY+2 cycles after the handshake, with the correct sum.

Source files
------------

// File: rtl/alu_arbiter.sv
// Two-requester round-robin front end for a shared, fixed-latency ALU.
// One operation is in flight at a time: IDLE accepts, EXEC waits out the ALU, RESP returns the result.
module alu_arbiter #(
    parameter int unsigned ALU_LATENCY = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid_0,
    input  logic        req_valid_1,
    output logic        req_ready_0,
    output logic        req_ready_1,
    input  logic [31:0] req_a_0,
    input  logic [31:0] req_b_0,
    input  logic [31:0] req_a_1,
    input  logic [31:0] req_b_1,
    input  logic [2:0]  req_op_0,
    input  logic [2:0]  req_op_1,
    input  logic        req_la_0,
    input  logic        req_la_1,
    input  logic        req_as_0,
    input  logic        req_as_1,
    output logic        rsp_valid_0,
    output logic        rsp_valid_1,
    output logic [31:0] rsp_data_0,
    output logic [31:0] rsp_data_1,
    input  logic        rsp_ready_0,
    input  logic        rsp_ready_1,
    output logic [31:0] alu_operand_a,
    output logic [31:0] alu_operand_b,
    output logic [2:0]  alu_operation,
    output logic        alu_logic_arithmetic,
    output logic        alu_add_sub,
    input  logic [31:0] alu_out,
    output logic        busy
);

    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_e;

    localparam logic [2:0] EXEC_LOAD = 3'(ALU_LATENCY);

    state_e      state_q;
    logic [31:0] a_q, b_q, result_q;
    logic [2:0]  op_q, cnt_q;
    logic        la_q, as_q, owner_q, last_grant_q;

    logic        grant_d;
    logic        sel_valid;
    logic        handshake;
    logic        rsp_release;

    // On a tie the requester that did not win last time is chosen.
    assign grant_d     = (req_valid_0 && req_valid_1) ? ~last_grant_q : req_valid_1;
    assign sel_valid   = grant_d ? req_valid_1 : req_valid_0;
    // NOTE: ready is gated by rst so no output can assert while reset is held.
    assign handshake   = (state_q == IDLE) && !rst && sel_valid;
    assign req_ready_0 = handshake && !grant_d;
    assign req_ready_1 = handshake && grant_d;
    assign rsp_release = owner_q ? rsp_ready_1 : rsp_ready_0;

    // NOTE: all state updates use non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            a_q          <= '0;
            b_q          <= '0;
            op_q         <= '0;
            la_q         <= 1'b0;
            as_q         <= 1'b0;
            owner_q      <= 1'b0;
            last_grant_q <= 1'b1;
            cnt_q        <= '0;
            result_q     <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (handshake) begin
                        a_q          <= grant_d ? req_a_1  : req_a_0;
                        b_q          <= grant_d ? req_b_1  : req_b_0;
                        op_q         <= grant_d ? req_op_1 : req_op_0;
                        la_q         <= grant_d ? req_la_1 : req_la_0;
                        as_q         <= grant_d ? req_as_1 : req_as_0;
                        owner_q      <= grant_d;
                        last_grant_q <= grant_d;
                        cnt_q        <= EXEC_LOAD;
                        state_q      <= EXEC;
                    end
                end
                EXEC: begin
                    if (cnt_q == 3'd0) begin
                        result_q <= alu_out;
                        state_q  <= RESP;
                    end else begin
                        cnt_q <= cnt_q - 3'd1;
                    end
                end
                RESP: begin
                    if (rsp_release) begin
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign alu_operand_a        = a_q;
    assign alu_operand_b        = b_q;
    assign alu_operation        = op_q;
    assign alu_logic_arithmetic = la_q;
    assign alu_add_sub          = as_q;

    assign busy        = (state_q != IDLE);
    assign rsp_valid_0 = (state_q == RESP) && !owner_q;
    assign rsp_valid_1 = (state_q == RESP) && owner_q;
    assign rsp_data_0  = rsp_valid_0 ? result_q : 32'd0;
    assign rsp_data_1  = rsp_valid_1 ? result_q : 32'd0;

endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: three instances (latency 1, 0, 3) share one stimulus stream and are
// compared every cycle against a transaction-level model, plus hand-computed literal checks.
module tb_alu_arbiter;

    localparam int N = 3;

    function automatic int lat_of(input int i);
        return (i == 0) ? 1 : (i == 1) ? 0 : 3;
    endfunction

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        v0 = 1'b0, v1 = 1'b0, rr0 = 1'b1, rr1 = 1'b1;
    logic [31:0] a0 = '0, b0 = '0, a1 = '0, b1 = '0;
    logic [2:0]  op0 = 3'd2, op1 = 3'd5;
    logic        la0 = 1'b1, la1 = 1'b0, as0 = 1'b0, as1 = 1'b1;

    logic [N-1:0] rdy0, rdy1, rv0, rv1, bsy, ala, aas;
    logic [31:0]  rd0 [N];
    logic [31:0]  rd1 [N];
    logic [31:0]  aa  [N];
    logic [31:0]  ab  [N];
    logic [31:0]  aout[N];
    logic [2:0]   aop [N];

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    for (genvar gi = 0; gi < N; gi++) begin : g_inst
        localparam int L = lat_of(gi);
        logic [31:0] pipe [0:3];

        alu_arbiter #(.ALU_LATENCY(L)) dut (
            .clk(clk), .rst(rst),
            .req_valid_0(v0), .req_valid_1(v1),
            .req_ready_0(rdy0[gi]), .req_ready_1(rdy1[gi]),
            .req_a_0(a0), .req_b_0(b0), .req_a_1(a1), .req_b_1(b1),
            .req_op_0(op0), .req_op_1(op1),
            .req_la_0(la0), .req_la_1(la1), .req_as_0(as0), .req_as_1(as1),
            .rsp_valid_0(rv0[gi]), .rsp_valid_1(rv1[gi]),
            .rsp_data_0(rd0[gi]), .rsp_data_1(rd1[gi]),
            .rsp_ready_0(rr0), .rsp_ready_1(rr1),
            .alu_operand_a(aa[gi]), .alu_operand_b(ab[gi]),
            .alu_operation(aop[gi]), .alu_logic_arithmetic(ala[gi]), .alu_add_sub(aas[gi]),
            .alu_out(aout[gi]), .busy(bsy[gi])
        );

        // ALU stub: sum delayed by L registers
        always @(posedge clk) begin
            pipe[0] <= aa[gi] + ab[gi];
            for (int k = 1; k < 4; k++) pipe[k] <= pipe[k-1];
        end
        if (L == 0) begin : g_comb
            assign aout[gi] = aa[gi] + ab[gi];
        end else begin : g_reg
            assign aout[gi] = pipe[L-1];
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Model: per instance, whether an op is pending, its owner and sum, and cycles left before RESP.
    bit          m_busy [N];
    int          m_wait [N];
    bit          m_owner[N];
    bit          m_lg   [N];
    logic [31:0] m_sum  [N];
    logic [31:0] m_a    [N];
    logic [31:0] m_b    [N];
    logic [2:0]  m_op   [N];
    bit          m_la   [N];
    bit          m_as   [N];

    function automatic int pick(input bit lg, input logic x0, input logic x1);
        if (x0 && x1) return lg ? 0 : 1;
        if (x0) return 0;
        if (x1) return 1;
        return -1;
    endfunction

    always @(posedge clk) begin
        for (int i = 0; i < N; i++) begin
            if (rst) begin
                m_busy[i] <= 1'b0; m_wait[i] <= 0; m_owner[i] <= 1'b0; m_lg[i] <= 1'b1;
                m_sum[i] <= '0; m_a[i] <= '0; m_b[i] <= '0; m_op[i] <= '0;
                m_la[i] <= 1'b0; m_as[i] <= 1'b0;
            end else if (!m_busy[i]) begin
                int g;
                g = pick(m_lg[i], v0, v1);
                if (g >= 0) begin
                    m_busy[i]  <= 1'b1;
                    m_owner[i] <= (g == 1);
                    m_lg[i]    <= (g == 1);
                    m_a[i]     <= (g == 1) ? a1 : a0;
                    m_b[i]     <= (g == 1) ? b1 : b0;
                    m_sum[i]   <= (g == 1) ? a1 + b1 : a0 + b0;
                    m_op[i]    <= (g == 1) ? op1 : op0;
                    m_la[i]    <= (g == 1) ? la1 : la0;
                    m_as[i]    <= (g == 1) ? as1 : as0;
                    m_wait[i]  <= lat_of(i) + 1;
                end
            end else if (m_wait[i] > 0) begin
                m_wait[i] <= m_wait[i] - 1;
            end else if (m_owner[i] ? rr1 : rr0) begin
                m_busy[i] <= 1'b0;
            end
        end
    end

    always @(negedge clk) begin
        for (int i = 0; i < N; i++) begin
            int  g;
            bit  resp;
            g    = pick(m_lg[i], v0, v1);
            resp = m_busy[i] && (m_wait[i] == 0);
            check($sformatf("i%0d_ready0", i), rdy0[i], !rst && !m_busy[i] && g == 0);
            check($sformatf("i%0d_ready1", i), rdy1[i], !rst && !m_busy[i] && g == 1);
            check($sformatf("i%0d_rsp_valid0", i), rv0[i], !rst && resp && !m_owner[i]);
            check($sformatf("i%0d_rsp_valid1", i), rv1[i], !rst && resp && m_owner[i]);
            check($sformatf("i%0d_rsp_data0", i), rd0[i], (!rst && resp && !m_owner[i]) ? m_sum[i] : 32'd0);
            check($sformatf("i%0d_rsp_data1", i), rd1[i], (!rst && resp && m_owner[i]) ? m_sum[i] : 32'd0);
            check($sformatf("i%0d_busy", i), bsy[i], !rst && m_busy[i]);
            check($sformatf("i%0d_alu_a", i), aa[i], rst ? 32'd0 : m_a[i]);
            check($sformatf("i%0d_alu_b", i), ab[i], rst ? 32'd0 : m_b[i]);
            check($sformatf("i%0d_alu_op", i), aop[i], rst ? 3'd0 : m_op[i]);
            check($sformatf("i%0d_alu_la", i), ala[i], !rst && m_la[i]);
            check($sformatf("i%0d_alu_as", i), aas[i], !rst && m_as[i]);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) step();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        rst = 1'b0;
    endtask

    initial begin
        int gseq[$];
        int gtime[$];
        int n_rsp0, n_rsp1;
        int first[N];

        // Reset: outputs stay low even with a request presented
        step();
        v0 = 1'b1;
        @(negedge clk);
        check("rst_ready0", rdy0[0], 1'b0);
        check("rst_busy", bsy[0], 1'b0);
        step();
        v0 = 1'b0;
        rst = 1'b0;

        // Single request: 2 + 1, response three cycles after handshake
        v0 = 1'b1; a0 = 32'd2; b0 = 32'd1;
        @(negedge clk);
        check("single_ready0", rdy0[0], 1'b1);
        step();
        v0 = 1'b0;
        for (int k = 1; k <= 3; k++) begin
            @(negedge clk);
            check($sformatf("single_valid_c%0d", k), rv0[0], k == 3);
            if (k == 3) check("single_data", rd0[0], 32'd3);
            step();
        end
        idle(8);

        // Ties after reset alternate 0,1,0,1 at the minimum spacing of four cycles
        do_reset();
        v0 = 1'b1; v1 = 1'b1; a0 = 32'd5; b0 = 32'd5; a1 = 32'd7; b1 = 32'd1;
        n_rsp0 = 0; n_rsp1 = 0;
        for (int c = 0; c < 30; c++) begin
            @(negedge clk);
            if (rdy0[0]) begin gseq.push_back(0); gtime.push_back(c); end
            if (rdy1[0]) begin gseq.push_back(1); gtime.push_back(c); end
            if (rv0[0]) begin n_rsp0++; check("tie_data0", rd0[0], 32'd10); end
            if (rv1[0]) begin n_rsp1++; check("tie_data1", rd1[0], 32'd8); end
            step();
        end
        v0 = 1'b0; v1 = 1'b0;
        check("tie_rsp_count", (n_rsp0 >= 3) && (n_rsp1 >= 3), 1'b1);
        check("tie_grant_count", gseq.size() >= 4, 1'b1);
        if (gseq.size() >= 4) begin
            for (int k = 0; k < 4; k++) check($sformatf("tie_grant%0d", k), gseq[k], k % 2);
            for (int k = 0; k < 3; k++) check($sformatf("tie_spacing%0d", k), gtime[k+1] - gtime[k], 4);
        end
        idle(8);

        // Backpressure: result held four cycles, req1 waits until the cycle after release
        v0 = 1'b1; a0 = 32'd3; b0 = 32'd4; rr0 = 1'b0;
        @(negedge clk);
        check("bp_ready0", rdy0[0], 1'b1);
        step();
        v0 = 1'b0; v1 = 1'b1; a1 = 32'd9; b1 = 32'd9;
        step();
        step();
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check($sformatf("bp_valid%0d", k), rv0[0], 1'b1);
            check($sformatf("bp_data%0d", k), rd0[0], 32'd7);
            check($sformatf("bp_ready1_%0d", k), rdy1[0], 1'b0);
            step();
        end
        rr0 = 1'b1;
        @(negedge clk);
        check("bp_release_ready1", rdy1[0], 1'b0);
        check("bp_release_valid0", rv0[0], 1'b1);
        step();
        @(negedge clk);
        check("bp_after_ready1", rdy1[0], 1'b1);
        step();
        v1 = 1'b0;
        idle(10);

        // Reset during the first EXEC cycle discards the op
        v0 = 1'b1; a0 = 32'd4; b0 = 32'd4;
        step();
        v0 = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        check("midrst_busy_in", bsy[0], 1'b0);
        step();
        rst = 1'b0;
        @(negedge clk);
        check("midrst_busy_after", bsy[0], 1'b0);
        check("midrst_valid_after", rv0[0], 1'b0);
        step();
        v1 = 1'b1; a1 = 32'd1; b1 = 32'd1;
        @(negedge clk);
        check("midrst_ready1", rdy1[0], 1'b1);
        step();
        v1 = 1'b0;
        for (int k = 1; k <= 3; k++) begin
            @(negedge clk);
            check($sformatf("midrst_valid0_c%0d", k), rv0[0], 1'b0);
            check($sformatf("midrst_valid1_c%0d", k), rv1[0], k == 3);
            if (k == 3) check("midrst_data1", rd1[0], 32'd2);
            step();
        end
        idle(8);

        // Latency sweep: response ALU_LATENCY+2 cycles after a common handshake
        do_reset();
        v0 = 1'b1; a0 = 32'd20; b0 = 32'd22;
        step();
        v0 = 1'b0;
        for (int i = 0; i < N; i++) first[i] = -1;
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            for (int i = 0; i < N; i++) begin
                if (rv0[i] && first[i] < 0) begin
                    first[i] = k;
                    check($sformatf("sweep_data_i%0d", i), rd0[i], 32'd42);
                end
            end
            step();
        end
        for (int i = 0; i < N; i++)
            check($sformatf("sweep_latency_i%0d", i), first[i], lat_of(i) + 2);
        idle(4);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
